// File: rtl/sbus_channel_decoder.sv
// SBUS frame unpacker: validates a captured 25-byte frame, streams its 16 channels one
// per cycle, commits an atomic channel/flag bank, and watches for loss of good frames.
module sbus_channel_decoder #(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [199:0]   sbus_frame,
  input  logic           sbus_frame_valid,
  output logic           ch_valid,
  output logic [3:0]     ch_idx,
  output logic [10:0]    ch_data,
  output logic [175:0]   channels,
  output logic           ch17,
  output logic           ch18,
  output logic           frame_lost,
  output logic           failsafe,
  output logic           frame_done,
  output logic           frame_err,
  output logic           overrun,
  output logic [7:0]     err_count,
  output logic           link_lost
);

  localparam int NUM_CH = 16;
  localparam int CH_W   = 11;
  localparam int NUM_PB = 22;
  localparam int LIMIT  = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int WD_W   = $clog2(LIMIT) + 1;

  typedef enum logic [1:0] {IDLE, CHECK, UNPACK, COMMIT} state_t;

  state_t                         r_state;
  logic [199:0]                   r_frame;
  logic [3:0]                     r_idx;
  logic [WD_W-1:0]                r_wd;
  logic [NUM_CH*CH_W-1:0]         w_payload;
  logic [NUM_CH-1:0][CH_W-1:0]    w_ch;
  logic [7:0]                     w_flags;
  logic                           w_hdr_ok;
  logic                           w_commit;
  logic                           w_unused_flags;

  // Payload byte k+1 lands in P[8k+7:8k]; bit 0 of each byte is the first wire bit.
  for (genvar k = 0; k < NUM_PB; k++) begin : g_pbyte
    assign w_payload[8*k +: 8] = r_frame[199-8*(k+1) -: 8];
  end

  assign w_ch           = w_payload;
  assign w_flags        = r_frame[15:8];
  assign w_unused_flags = ^w_flags[7:4];
  assign w_hdr_ok       = (r_frame[199:192] == 8'h0F) && (r_frame[7:0] == 8'h00);
  assign w_commit       = (r_state == COMMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_frame    <= '0;
      r_idx      <= '0;
      ch_valid   <= 1'b0;
      ch_idx     <= '0;
      ch_data    <= '0;
      channels   <= '0;
      ch17       <= 1'b0;
      ch18       <= 1'b0;
      frame_lost <= 1'b0;
      failsafe   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      err_count  <= '0;
    end else begin
      ch_valid   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= sbus_frame_valid && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (sbus_frame_valid) begin
            r_frame <= sbus_frame;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          // Channel 0 is emitted here so the stream starts the cycle after CHECK.
          if (w_hdr_ok) begin
            ch_valid <= 1'b1;
            ch_idx   <= 4'd0;
            ch_data  <= w_ch[0];
            r_idx    <= 4'd1;
            r_state  <= UNPACK;
          end else begin
            frame_err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            r_state <= IDLE;
          end
        end
        UNPACK: begin
          ch_valid <= 1'b1;
          ch_idx   <= r_idx;
          ch_data  <= w_ch[r_idx];
          r_idx    <= r_idx + 4'd1;
          if (r_idx == 4'd15) r_state <= COMMIT;
        end
        COMMIT: begin
          channels   <= w_payload;
          ch17       <= w_flags[0];
          ch18       <= w_flags[1];
          frame_lost <= w_flags[2];
          failsafe   <= w_flags[3];
          frame_done <= 1'b1;
          r_idx      <= 4'd0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Commit has priority over the limit so a good frame always clears the flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wd      <= '0;
      link_lost <= 1'b1;
    end else if (w_commit) begin
      r_wd      <= '0;
      link_lost <= 1'b0;
    end else if (r_wd < WD_W'(LIMIT)) begin
      r_wd <= r_wd + WD_W'(1);
      if (r_wd == WD_W'(LIMIT - 1)) link_lost <= 1'b1;
    end else begin
      link_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sbus_channel_decoder.sv
// Directed bench for sbus_channel_decoder with a 10-cycle watchdog.
module tb_sbus_channel_decoder;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [199:0]   sbus_frame = '0;
  logic           sbus_frame_valid = 1'b0;
  logic           ch_valid;
  logic [3:0]     ch_idx;
  logic [10:0]    ch_data;
  logic [175:0]   channels;
  logic           ch17, ch18, frame_lost, failsafe;
  logic           frame_done, frame_err, overrun;
  logic [7:0]     err_count;
  logic           link_lost;

  int checks = 0;
  int failures = 0;

  sbus_channel_decoder #(.CLK_HZ(1000), .TIMEOUT_MS(10)) dut (
    .clk(clk), .resetn(resetn), .sbus_frame(sbus_frame), .sbus_frame_valid(sbus_frame_valid),
    .ch_valid(ch_valid), .ch_idx(ch_idx), .ch_data(ch_data), .channels(channels),
    .ch17(ch17), .ch18(ch18), .frame_lost(frame_lost), .failsafe(failsafe),
    .frame_done(frame_done), .frame_err(frame_err), .overrun(overrun),
    .err_count(err_count), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [175:0] got, input logic [175:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [175:0] mk_bank(input logic [10:0] ch [16]);
    logic [175:0] b;
    for (int n = 0; n < 16; n++)
      for (int j = 0; j < 11; j++) b[11*n + j] = ch[n][j];
    return b;
  endfunction

  function automatic logic [199:0] mk_frame(input logic [175:0] b, input logic [7:0] flags,
                                            input logic [7:0] hdr);
    logic [199:0] f;
    f = '0;
    f[199:192] = hdr;
    for (int k = 1; k <= 22; k++) f[199-8*k -: 8] = b[8*(k-1) +: 8];
    f[15:8] = flags;
    f[7:0]  = 8'h00;
    return f;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"},  176'(ch_valid), '0);
    chk({tag, "_idx"},  176'(ch_idx), '0);
    chk({tag, "_data"}, 176'(ch_data), '0);
    chk({tag, "_bank"}, channels, '0);
    chk({tag, "_flg"},  176'({failsafe, frame_lost, ch18, ch17}), '0);
    chk({tag, "_pls"},  176'({frame_done, frame_err, overrun}), '0);
    chk({tag, "_errc"}, 176'(err_count), '0);
    chk({tag, "_lost"}, 176'(link_lost), 176'(1));
  endtask

  task automatic run_good(input logic [199:0] f, input logic [175:0] eb, input logic [3:0] ef,
                          input bit inj, input logic [199:0] f2);
    @(negedge clk);
    sbus_frame = f;
    sbus_frame_valid = 1'b1;
    @(posedge clk); #1;
    sbus_frame_valid = 1'b0;
    chk("check_no_vld", 176'(ch_valid), '0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk("stream_vld",  176'(ch_valid), 176'(1));
      chk("stream_idx",  176'(ch_idx), 176'(i));
      chk("stream_data", 176'(ch_data), 176'(eb[11*i +: 11]));
      chk("stream_no_done", 176'(frame_done), '0);
      if (inj && i == 3) begin
        sbus_frame = f2;
        sbus_frame_valid = 1'b1;
      end
      if (inj && i == 4) begin
        chk("overrun", 176'(overrun), 176'(1));
        sbus_frame_valid = 1'b0;
      end
      if (inj && i == 5) chk("overrun_pulse", 176'(overrun), '0);
    end
    @(posedge clk); #1;
    chk("done",      176'(frame_done), 176'(1));
    chk("done_vld",  176'(ch_valid), '0);
    chk("idx_hold",  176'(ch_idx), 176'(15));
    chk("bank",      channels, eb);
    chk("flags",     176'({failsafe, frame_lost, ch18, ch17}), 176'(ef));
    chk("lost_clr",  176'(link_lost), '0);
  endtask

  logic [10:0]  chv [16];
  logic [7:0]   bt [25];
  logic [175:0] bank_a, bank_b, bank_c;
  logic [199:0] fr_a, fr_b, fr_c, fr_bad;
  bit           seen;

  initial begin
    // Reset state
    #12;
    chk_reset("rst");
    @(negedge clk);
    resetn = 1'b1;

    // Good frame: all channels 0x400, flags 0x03, then watchdog expiry
    for (int n = 0; n < 16; n++) chv[n] = 11'h400;
    bank_a = mk_bank(chv);
    fr_a   = mk_frame(bank_a, 8'h03, 8'h0F);
    run_good(fr_a, bank_a, 4'b0011, 1'b0, '0);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("done_pulse", 176'(frame_done), '0);
    end
    chk("wd_before", 176'(link_lost), '0);
    @(posedge clk); #1;
    chk("wd_expire", 176'(link_lost), 176'(1));

    // Bit packing: frame bytes written by hand, flags 0x0C; commit clears a saturated watchdog
    for (int k = 0; k < 25; k++) bt[k] = 8'h00;
    bt[0] = 8'h0F; bt[1] = 8'hFF; bt[2] = 8'h0F; bt[21] = 8'hA0; bt[22] = 8'hAA; bt[23] = 8'h0C;
    fr_b = '0;
    for (int k = 0; k < 25; k++) fr_b[199-8*k -: 8] = bt[k];
    for (int n = 0; n < 16; n++) chv[n] = 11'h000;
    chv[0] = 11'h7FF; chv[1] = 11'h001; chv[15] = 11'h555;
    bank_b = mk_bank(chv);
    run_good(fr_b, bank_b, 4'b1100, 1'b0, '0);

    // Bad header: error pulse and count, bank untouched, no stream
    for (int n = 0; n < 16; n++) chv[n] = 11'h123;
    fr_bad = mk_frame(mk_bank(chv), 8'h0F, 8'h0E);
    chk("errc_pre", 176'(err_count), '0);
    @(negedge clk);
    sbus_frame = fr_bad;
    sbus_frame_valid = 1'b1;
    @(posedge clk); #1;
    sbus_frame_valid = 1'b0;
    chk("err_early", 176'(frame_err), '0);
    @(posedge clk); #1;
    chk("err_pulse", 176'(frame_err), 176'(1));
    chk("errc_inc",  176'(err_count), 176'(1));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) chk("err_width", 176'(frame_err), '0);
      if (ch_valid || frame_done) seen = 1'b1;
    end
    chk("bad_no_stream", 176'(seen), '0);
    chk("bad_bank",  channels, bank_b);
    chk("bad_flags", 176'({failsafe, frame_lost, ch18, ch17}), 176'(4'b1100));
    chk("bad_lost",  176'(link_lost), 176'(1));

    // Overrun: second strobe during UNPACK is dropped
    for (int n = 0; n < 16; n++) chv[n] = 11'(n * 37 + 5);
    bank_c = mk_bank(chv);
    fr_c   = mk_frame(bank_c, 8'h05, 8'h0F);
    run_good(fr_c, bank_c, 4'b0101, 1'b1, fr_a);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (frame_done || ch_valid) seen = 1'b1;
    end
    chk("ovr_single_done", 176'(seen), '0);
    chk("ovr_bank", channels, bank_c);

    // Reset in the middle of UNPACK, then a clean decode
    @(negedge clk);
    sbus_frame = fr_a;
    sbus_frame_valid = 1'b1;
    @(posedge clk); #1;
    sbus_frame_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk_reset("mid");
    @(negedge clk);
    resetn = 1'b1;
    run_good(fr_b, bank_b, 4'b1100, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sbus_channel_decoder.md
# sbus_channel_decoder

Unpacks 25-byte SBUS frames from the SBUS frame assembler (`sbus_frame` / `sbus_frame_valid`) into sixteen 11-bit proportional channels, the two digital channels and the link status flags. It streams channels one per cycle for downstream consumers, commits an atomic parallel channel bank per good frame, and runs a watchdog that flags link loss when good frames stop arriving. It sits directly downstream of the SBUS frame assembler in `impl_top`.

## Interface
- `CLK_HZ`, 50000000, system clock frequency in Hz.
- `TIMEOUT_MS`, 100, watchdog period with no good frame before `link_lost` asserts.
- `clk` input 1: system clock.
- `resetn` input 1: **asynchronous, active-low reset.**
- `sbus_frame` input 200: assembled frame. Byte k (0..24) is `sbus_frame[199-8k -: 8]`, with bit 0 of each byte being the first data bit on the wire.
- `sbus_frame_valid` input 1: single-cycle strobe; `sbus_frame` is stable in that cycle.
- `ch_valid` output 1: streamed channel strobe.
- `ch_idx` output 4: streamed channel index, 0..15.
- `ch_data` output 11: streamed channel value.
- `channels` output 176: committed bank; channel n is at `[11n+10:11n]`.
- `ch17`, `ch18`, `frame_lost`, `failsafe` output 1 each: committed flag bits.
- `frame_done` output 1: pulse when the bank commits.
- `frame_err` output 1: pulse when a frame is rejected.
- `overrun` output 1: pulse when a strobe is dropped while busy.
- `err_count` output 8: number of rejected frames, saturating at 255.
- `link_lost` output 1: watchdog flag.

## Operation
- **Frame format**
  - Header: byte 0 must equal 0x0F.
  - Footer: byte 24 must equal 0x00.
  - Payload P: 176 bits, P = {byte22, …, byte1}, with byte1 in P[7:0].
  - Channel n = P[11n+10:11n].
  - Flags byte 23: bit0 = ch17, bit1 = ch18, bit2 = frame_lost, bit3 = failsafe. Bits 7:4 are ignored.
- **FSM states:** IDLE, CHECK, UNPACK, COMMIT.
  - IDLE: on `sbus_frame_valid`, capture the frame into a 200-bit register and go to CHECK.
  - CHECK: if the header and footer match, go to UNPACK with idx = 0. Otherwise pulse `frame_err`, increment `err_count` (saturating), and go to IDLE.
  - UNPACK: assert `ch_valid` with `ch_idx` = idx and `ch_data` = channel idx from the captured frame. Increment idx. After idx 15, go to COMMIT.
  - COMMIT: load `channels` and the four flags from the captured frame, pulse `frame_done`, clear the watchdog, clear `link_lost`, and go to IDLE.
- **Busy behaviour:** `sbus_frame_valid` in CHECK, UNPACK or COMMIT is ignored. The captured frame is not modified, and `overrun` pulses in the next cycle.
- **Committed bank stability:** `channels` and the flags change only in COMMIT. A rejected frame leaves them unchanged.
- **Watchdog**
  - Free-running counter with limit `CLK_HZ/1000*TIMEOUT_MS`; width is `$clog2` of the limit, plus 1.
  - The counter increments every cycle it is below the limit and saturates at the limit.
  - Reaching the limit sets `link_lost`.
  - COMMIT resets the count to 0 and clears `link_lost` in the same cycle.
  - Rejected frames do not reset the watchdog.

## Timing
- **Reset values:** all outputs are 0 except `link_lost`, which is 1 (no link until the first good frame). FSM resets to IDLE, watchdog count to 0, idx to 0.
- **Reset mid-frame:** immediately abandons processing and asserts the reset values. The bank does not partially update.
- **Good-frame latency:** with `sbus_frame_valid` sampled at edge T:
  - CHECK is active in cycle T+1.
  - `ch_valid` is high in cycles T+2 .. T+17 (idx 0..15, consecutive, no gaps).
  - `frame_done` and the bank update occur in cycle T+18.
  - The next strobe is accepted in cycle T+19 or later.
- **Bad-frame latency:** `frame_err` pulses in cycle T+2, and `err_count` updates in the same cycle. The next strobe is accepted in cycle T+2 or later.
- **Output stability:**
  - `ch_idx` and `ch_data` hold their last values when `ch_valid` is low.
  - All outputs are registered.
  - All pulses are exactly 1 cycle wide.
- **Simultaneous events:** if the watchdog reaches its limit in the same cycle as COMMIT, COMMIT wins and `link_lost` stays 0.

## Test plan
- **Good frame.** Stimulus: header 0x0F, footer 0x00, all channels 0x400, flags 0x03, strobe at T. Required response: 16 `ch_valid` cycles T+2..T+17 with `ch_data` = 0x400 and idx 0..15; `frame_done` at T+18; `channels` = 16×0x400; `ch17` = `ch18` = 1; `frame_lost` = `failsafe` = 0.
- **Bit packing.** Stimulus: ch0 = 0x7FF, ch1 = 0x001, ch15 = 0x555, all others 0. Required response: byte1 = 0xFF, byte2 = 0x0F; decoded values match exactly, and the neighbouring channels are 0.
- **Bad frame.** Stimulus: header 0x0E after a good frame. Required response: `frame_err` at T+2; `err_count` goes 0→1; `channels` and flags unchanged; no `ch_valid` or `frame_done`.
- **Overrun.** Stimulus: a second strobe at T+5 during UNPACK. Required response: `overrun` at T+6; the stream continues with values from the first frame; exactly one `frame_done`.
- **Watchdog.** Stimulus: `CLK_HZ` = 1000, `TIMEOUT_MS` = 10 (limit 10). Required response: after a good frame, `link_lost` rises 10 cycles after COMMIT when no further good frame arrives; a good frame clears it at its COMMIT cycle; bad frames do not clear it.
- **Reset mid-UNPACK.** Stimulus: drop `resetn` at T+8. Required response: all outputs return to reset values asynchronously, `link_lost` = 1, and a subsequent good frame decodes normally.
